// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Desc     : Shared types and helpers for the adder arbiter (tags, response
//            record, round-robin pick).
// Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    localparam int c_MAX_NREQ = 16;
    localparam int c_TAG_W    = 4;
    localparam int c_MAX_W    = 64;

    function automatic int tag_width(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    // Sized for the largest supported requester count; narrower builds carry
    // constant-zero upper bits.
    typedef logic [c_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic [c_MAX_W-1:0] sum;
        logic               c_out;
        tag_t               tag;
    } rsp_t;

    // One-hot grant of the first asserted request at or after ptr, wrapping
    // modulo nreq.
    function automatic logic [c_MAX_NREQ-1:0] rr_pick(
        input logic [c_MAX_NREQ-1:0] req,
        input int                    nreq,
        input tag_t                  ptr
    );
        logic [c_MAX_NREQ-1:0] grant;
        logic                  found;
        logic [c_TAG_W-1:0]    idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < c_MAX_NREQ; i++) begin
            idx = c_TAG_W'((int'(ptr) + i) % nreq);
            if ((i < nreq) && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arb_tagfifo.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_tagfifo
// Desc     : Synchronous in-order FIFO of requester tags, depth DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arb_tagfifo
    import adder_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  tag_t                         push_tag,
    input  logic                         pop,
    output tag_t                         pop_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    tag_t             r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr;
    logic [c_PW-1:0]  r_rd;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == c_CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign pop_tag = r_mem[r_rd];
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == c_PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb
// Desc     : Round-robin front end sharing one external pipelined adder among
//            NREQ requesters; results are steered back via an in-order tag
//            FIFO. Define ADDER_ARB_CHECK_EN for sticky protocol error + asserts.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int W     = 32,
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_c_in,
    output logic              add_in_valid,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_c_in,
    input  logic [W-1:0]      add_sum,
    input  logic              add_c_out,
    input  logic              add_out_valid,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_c_out,
    output logic              idle,
    output logic              err
);

    localparam int c_TW = tag_width(NREQ);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [c_TW-1:0]  r_ptr;
    logic             r_add_in_valid;
    logic [W-1:0]     r_add_a;
    logic [W-1:0]     r_add_b;
    logic             r_add_c_in;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [W-1:0]     r_rsp_sum;
    logic             r_rsp_c_out;

    logic [NREQ-1:0]  w_grant;
    logic             w_fire;
    logic [c_TW-1:0]  w_gidx;
    logic [c_TW-1:0]  w_ptr_nxt;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_sel_c;
    logic             w_pop;
    tag_t             w_pop_tag;
    logic [c_CW-1:0]  w_count;
    logic             w_full;
    logic             w_empty;

    // A pop in the same cycle does not free a slot; grant only below DEPTH.
    assign w_grant   = w_full ? '0
                     : NREQ'(rr_pick(c_MAX_NREQ'(req_valid), NREQ, tag_t'(r_ptr)));
    assign req_ready = w_grant;
    assign w_fire    = |w_grant;
    assign w_pop     = add_out_valid & ~w_empty;
    assign w_ptr_nxt = (w_gidx == c_TW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_gidx  = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_c = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx  = c_TW'(i);
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
                w_sel_c = req_c_in[i];
            end
        end
    end

    adder_arb_tagfifo #(
        .DEPTH (DEPTH)
    ) u_tagfifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_fire),
        .push_tag (tag_t'(w_gidx)),
        .pop      (w_pop),
        .pop_tag  (w_pop_tag),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_add_in_valid <= 1'b0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_c_in     <= 1'b0;
            r_rsp_valid    <= '0;
            r_rsp_sum      <= '0;
            r_rsp_c_out    <= 1'b0;
        end else begin
            r_add_in_valid <= w_fire;
            if (w_fire) begin
                r_add_a    <= w_sel_a;
                r_add_b    <= w_sel_b;
                r_add_c_in <= w_sel_c;
                r_ptr      <= w_ptr_nxt;
            end
            r_rsp_valid <= w_pop ? (NREQ'(1) << w_pop_tag) : '0;
            if (w_pop) begin
                r_rsp_sum   <= add_sum;
                r_rsp_c_out <= add_c_out;
            end
        end
    end

    assign add_in_valid = r_add_in_valid;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_c_in     = r_add_c_in;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_sum      = r_rsp_sum;
    assign rsp_c_out    = r_rsp_c_out;
    assign idle         = (w_count == '0) & ~r_add_in_valid & ~(|r_rsp_valid);

`ifdef ADDER_ARB_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((add_out_valid & w_empty) | (w_fire & w_full)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adder_arb
// Desc     : Directed self-checking bench for adder_arb with a behavioural
//            variable-latency adder attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arb;

    localparam int W     = 32;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int WP1   = W + 1;
`ifdef ADDER_ARB_CHECK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_c_in = '0;
    logic              add_in_valid, add_c_in, add_c_out, add_out_valid;
    logic [W-1:0]      add_a, add_b, add_sum, rsp_sum;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_c_out, idle, err;

    int   errors = 0;
    int   checks = 0;
    int   lat    = LAT;
    logic inj    = 1'b0;

    always #5 clk = ~clk;

    // Behavioural adder: lat register stages, shares rst.
    logic         pv [16];
    logic [W:0]   pr [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= add_in_valid;
            pr[0] <= {1'b0, add_a} + {1'b0, add_b} + WP1'(add_c_in);
            for (int i = 1; i < 16; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end
    assign add_out_valid = pv[lat-1] | inj;
    assign add_sum       = pr[lat-1][W-1:0];
    assign add_c_out     = pr[lat-1][W];

    adder_arb #(.W(W), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in),
        .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
        .add_sum(add_sum), .add_c_out(add_c_out), .add_out_valid(add_out_valid),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out),
        .idle(idle), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c_in[i]     = c;
    endtask

    task automatic do_reset();
        req_valid = '0;
        inj       = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       cin;
        logic [W-1:0] sum;
        logic       cout;
    } vec_t;

    vec_t vt [6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, rn, first, last, grants;

        vt[0] = '{1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, 1'b0};
        vt[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vt[2] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
        vt[3] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vt[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[5] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

        // Reset state
        do_reset();
        check("rst_ready", req_ready, 0);
        check("rst_add_in_valid", add_in_valid, 0);
        check("rst_add_a", add_a, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err, 0);

        // Single-requester vectors: grant, latency (handshake edge to rsp
        // edge inclusive = LAT+2), steering and result.
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < NREQ; k++)
                set_op(k, 32'hDEAD_0000 | k, 32'h0BAD_0000 | k, 1'b1);
            set_op(vt[v].idx, vt[v].a, vt[v].b, vt[v].cin);
            req_valid = NREQ'(1) << vt[v].idx;
            #1;
            check("vec_ready", req_ready, 1 << vt[v].idx);
            @(posedge clk);
            n = 1;
            @(negedge clk);
            req_valid = '0;
            while (rsp_valid == 0 && n < 40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            #1;
            check("vec_latency", n, LAT + 2);
            check("vec_rsp_valid", rsp_valid, 1 << vt[v].idx);
            check("vec_sum", rsp_sum, vt[v].sum);
            check("vec_c_out", rsp_c_out, vt[v].cout);
            check("vec_idle_busy", idle, 0);
            @(negedge clk);
            #1;
            check("vec_idle_after", idle, 1);
        end

        // All requesters continuously from ptr=0; req k gets 0xFFFFFFFF+(k+1).
        do_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, 32'hFFFF_FFFF, W'(k + 1), 1'b0);
        rn = 0; first = -1; last = -1;
        for (int c = 0; c < 24; c++) begin
            req_valid = (c < 8) ? '1 : '0;
            #1;
            if (c < 8) check("rr_grant", req_ready, NREQ'(1) << (c % NREQ));
            if (rsp_valid != 0) begin
                check("rr_rsp_owner", rsp_valid, 1 << (rn % NREQ));
                check("rr_rsp_sum", rsp_sum, rn % NREQ);
                check("rr_rsp_c_out", rsp_c_out, 1);
                if (first < 0) first = c;
                last = c;
                rn++;
            end
            @(negedge clk);
        end
        check("rr_rsp_count", rn, 8);
        check("rr_back_to_back", last - first, 7);

        // Saturation: adder latency beyond DEPTH, req 0 held.
        do_reset();
        lat = 8;
        set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        req_valid = 4'b0001;
        grants = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (add_out_valid) break;
            if (req_ready != 0) grants++;
            @(negedge clk);
        end
        check("sat_grants", grants, DEPTH);
        check("sat_ready_during_pop", req_ready, 0);
        @(negedge clk);
        #1;
        check("sat_ready_resume", req_ready, 1);
        req_valid = '0;
        rn = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid != 0) begin
                check("sat_rsp_sum", rsp_sum, 32'h30);
                rn++;
            end
            @(negedge clk);
            #1;
        end
        check("sat_rsp_count", rn, DEPTH);
        check("sat_idle", idle, 1);
        lat = LAT;

        // Reset while three ops are in flight.
        do_reset();
        lat = 6;
        for (int k = 0; k < 3; k++) set_op(k, 32'h100 + k, 32'h1, 1'b1);
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mid_grant", req_ready, 1 << c);
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        check("mid_busy", idle, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_add_in_valid", add_in_valid, 0);
        check("mid_add_a", add_a, 0);
        check("mid_add_c_in", add_c_in, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_idle", idle, 1);
        rn = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid != 0) rn++;
            @(negedge clk);
            #1;
        end
        check("mid_no_rsp", rn, 0);
        check("mid_idle_end", idle, 1);
        lat = LAT;

        // Unmatched adder result with the FIFO empty.
        do_reset();
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        check("chk_err_set", err, c_EXP_ERR);
        check("chk_no_rsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        #1;
        check("chk_err_sticky", err, c_EXP_ERR);
        check("chk_no_rsp_later", rsp_valid, 0);
        do_reset();
        check("chk_err_cleared", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
